// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline control logic and the stall/flush
// controller. The master side is the core (hazard/EX/exception sources), the
// slave side is pipe_stall_ctrl.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    logic              stallreq_id;
    logic              mc_req;
    logic [CNT_W-1:0]  mc_cycles;
    logic              flush_req;
    logic [5:0]        stall;
    logic              flush;
    logic              mc_start;
    logic              mc_busy;
    logic              mc_done;
    logic              mc_cancel;
    logic [CNT_W-1:0]  mc_cnt;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output stallreq_id, mc_req, mc_cycles, flush_req,
        input  stall, flush, mc_start, mc_busy, mc_done, mc_cancel, mc_cnt, stall_cnt
    );

    modport slave (
        input  stallreq_id, mc_req, mc_cycles, flush_req,
        output stall, flush, mc_start, mc_busy, mc_done, mc_cancel, mc_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage core. Merges the decode
// load-use stall with multi-cycle EX operations, sequences each multi-cycle
// op through IDLE -> RUN -> DONE, and counts stalled cycles (saturating).
// Outputs are combinational from state and current inputs so a hazard raised
// this cycle holds the pipeline this same cycle.
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0]        STALL_NONE = 6'b000000;
    localparam logic [5:0]        STALL_ID   = 6'b000111; // ex gets a bubble
    localparam logic [5:0]        STALL_MC   = 6'b001111; // mem gets a bubble
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_ONE   = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX   = {PERF_W{1'b1}};

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    logic [CNT_W-1:0]  w_len;
    logic [5:0]        w_stall;
    logic              w_flush;
    logic              w_mc_start;
    logic              w_mc_busy;
    logic              w_mc_done;
    logic              w_mc_cancel;
    logic [CNT_W-1:0]  w_mc_cnt;
    logic [PERF_W-1:0] w_stall_cnt;

    // A zero-length request still needs one RUN cycle.
    assign w_len = (bus.mc_cycles == CNT_ZERO) ? CNT_ONE : bus.mc_cycles;

    // Output decode: flush wins, then multi-cycle sequencing, then load-use stall.
    always_comb begin
        w_stall     = STALL_NONE;
        w_flush     = 1'b0;
        w_mc_start  = 1'b0;
        w_mc_busy   = 1'b0;
        w_mc_done   = 1'b0;
        w_mc_cancel = 1'b0;
        w_mc_cnt    = CNT_ZERO;
        w_stall_cnt = {PERF_W{1'b0}};
        if (rst) begin
            w_stall = STALL_NONE;
        end else if (bus.flush_req) begin
            w_flush     = 1'b1;
            w_mc_cancel = (r_state != ST_IDLE);
            w_stall_cnt = r_stall_cnt;
        end else begin
            w_stall_cnt = r_stall_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.mc_req) begin
                        w_mc_start = 1'b1;
                        w_stall    = STALL_MC;
                    end else if (bus.stallreq_id) begin
                        w_stall = STALL_ID;
                    end else begin
                        w_stall = STALL_NONE;
                    end
                end
                ST_RUN: begin
                    w_mc_busy = 1'b1;
                    w_mc_cnt  = r_cnt;
                    w_stall   = STALL_MC;
                end
                ST_DONE: begin
                    // mc_req still reflects the completing op here, so ignore it.
                    w_mc_done = 1'b1;
                    w_stall   = bus.stallreq_id ? STALL_ID : STALL_NONE;
                end
                default: begin
                    w_stall = STALL_NONE;
                end
            endcase
        end
    end

    // FSM, remaining-cycle counter and saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_stall_cnt <= {PERF_W{1'b0}};
        end else begin
            if (w_stall[0] && (r_stall_cnt != PERF_MAX)) begin
                r_stall_cnt <= r_stall_cnt + PERF_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (bus.flush_req) begin
                r_state <= ST_IDLE;
                r_cnt   <= CNT_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.mc_req) begin
                            r_state <= ST_RUN;
                            r_cnt   <= w_len - CNT_ONE;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= CNT_ZERO;
                        end
                    end
                    ST_RUN: begin
                        if (r_cnt == CNT_ZERO) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign bus.stall     = w_stall;
    assign bus.flush     = w_flush;
    assign bus.mc_start  = w_mc_start;
    assign bus.mc_busy   = w_mc_busy;
    assign bus.mc_done   = w_mc_done;
    assign bus.mc_cancel = w_mc_cancel;
    assign bus.mc_cnt    = w_mc_cnt;
    assign bus.stall_cnt = w_stall_cnt;
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline stall/flush controller for the 5-stage openMIPS core.
- Merges the decode-stage load-use stall request with multi-cycle execute operations (mult-accumulate, divide).
- Sequences each multi-cycle operation through a small FSM and cycle counter.
- Drives the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 6, width of the multi-cycle length input and the remaining-cycle counter
PERF_W, 32, width of the stall performance counter

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset (`RstEnable = 1'b1`)
stallreq_id  input  1  decode-stage load-use hazard request; level, combinational
mc_req  input  1  EX stage holds a multi-cycle op; held high while that op sits in EX
mc_cycles  input  CNT_W  execution length N of the op in EX; sampled only on acceptance; 0 treated as 1
flush_req  input  1  exception/redirect flush request; level
stall  output  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold that stage
flush  output  1  flush all pipeline registers this cycle
mc_start  output  1  one-cycle pulse telling the EX unit to begin the operation
mc_busy  output  1  high while the FSM is in RUN
mc_done  output  1  one-cycle pulse; EX result is valid and advances this cycle
mc_cancel  output  1  one-cycle pulse; abort the in-flight EX unit operation
mc_cnt  output  CNT_W  remaining RUN cycles; 0 outside RUN
stall_cnt  output  PERF_W  count of cycles with stall[0]=1; saturates at all-ones

Behaviour:
- FSM states: IDLE, RUN, DONE. Register `cnt` (CNT_W) and `stall_cnt`.
- Outputs are combinational from the state and the current inputs. While rst=1, every output is forced to 0.
- Reset, applied at any edge and in any state, including mid-RUN: state=IDLE, cnt=0, stall_cnt=0. No mc_cancel is issued.
- Let N = (mc_cycles==0) ? 1 : mc_cycles.
- Priority order: flush_req > multi-cycle sequencing > stallreq_id.
- flush_req=1, in any state:
  - flush=1, stall=6'b000000, mc_start=0, mc_done=0.
  - mc_cancel=1 if the state is RUN or DONE.
  - Next state=IDLE, cnt<=0.
- IDLE, no flush, mc_req=1 (acceptance cycle):
  - mc_start=1, stall=6'b001111 (pc/if/id/ex held; mem receives a bubble).
  - Next state=RUN, cnt<=N-1.
- IDLE, no flush, mc_req=0:
  - stallreq_id=1 gives stall=6'b000111 (ex receives a bubble); otherwise stall=0.
  - Next state=IDLE.
- RUN:
  - mc_busy=1, mc_cnt=cnt, stall=6'b001111. stallreq_id is ignored (covered by the mc stall).
  - cnt==0: next state=DONE. Otherwise cnt<=cnt-1.
  - RUN therefore lasts exactly N cycles.
- DONE:
  - mc_done=1.
  - mc_req is ignored this cycle: it still reflects the completing op.
  - stall=6'b000111 if stallreq_id=1, else 0.
  - Next state=IDLE.
- Timeline for acceptance at cycle T:
  - stall asserted T..T+N.
  - mc_done at T+N+1.
  - The op occupies EX for N+2 cycles.
- Back-to-back ops: a new multi-cycle op can be accepted no earlier than T+N+2.
- mc_req dropping during RUN (no flush) is ignored; the sequence completes normally.
- mc_cycles changing after acceptance has no effect.
- stall_cnt increments each non-reset cycle with stall[0]=1 and holds at 2^PERF_W-1.
- stall_cnt does not increment on flush cycles, since stall=0 then.

Test Plan:
- Reset with mc_req=1, stallreq_id=1 → stall=0, flush=0, mc_start=0, stall_cnt=0. The first cycle after reset with mc_req=1 gives mc_start=1.
- stallreq_id=1 for one cycle in IDLE → stall=6'b000111 in that cycle only; stall_cnt=1.
- mc_req=1, mc_cycles=3 at T:
  - mc_start at T; stall=6'b001111 at T..T+3.
  - mc_busy at T+1..T+3 with mc_cnt=2,1,0.
  - mc_done at T+4 with stall=0.
  - stall_cnt=4.
- mc_cycles=0 at T → treated as N=1: stall at T,T+1; mc_done at T+2.
- mc_cycles=5 at T, flush_req=1 at T+2:
  - T+2: flush=1, stall=0, mc_cancel=1.
  - T+3: state IDLE, mc_cnt=0.
- mc_req held high continuously, mc_cycles=2 at T:
  - T+3 (DONE): mc_done=1, no mc_start.
  - mc_start again at T+4.
  - stallreq_id=1 during RUN → stall stays 6'b001111.
